// File: rtl/bdi_line_packer.sv
// Pairs compressed BDI cachelines into 32-byte slots for the compressed data array.
// A lone line is emitted by itself after HOLD_TIMEOUT idle cycles or on flush.
module bdi_line_packer #(
  parameter int         WORD_WIDTH    = 32,
  parameter int         HOLD_TIMEOUT  = 16,
  parameter logic [3:0] RPV4_CODE     = 4'b0000,
  parameter logic [3:0] RPV8_CODE     = 4'b0001,
  parameter logic [3:0] B8D1_CODE     = 4'b0010,
  parameter logic [3:0] B4D1_CODE     = 4'b0011,
  parameter logic [3:0] B8D4_CODE     = 4'b0100,
  parameter logic [3:0] B8D2_CODE     = 4'b0101,
  parameter logic [3:0] B4D2_CODE     = 4'b0110,
  parameter logic [3:0] B2D1_CODE     = 4'b0111,
  parameter logic [3:0] NO_COMPR_CODE = 4'b1111
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*WORD_WIDTH-1:0] in_data,
  input  logic [3:0]              in_mode,
  input  logic [15:0]             in_base_one_hot,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [8*WORD_WIDTH-1:0] out_compressed_cachelines,
  output logic [7:0]              out_compressed_mode,
  output logic [31:0]             out_base_one_hot,
  output logic [1:0]              out_cacheline_valid,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int SW = 8 * WORD_WIDTH;
  localparam int SB = WORD_WIDTH;
  localparam int CW = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_TIMEOUT - 1);
  localparam logic [6:0]    FULL    = 7'(SB);

  function automatic logic [6:0] line_size(input logic [3:0] mode);
    case (mode)
      RPV4_CODE: return 7'd4;
      RPV8_CODE: return 7'd8;
      B8D1_CODE: return 7'd12;
      B4D1_CODE: return 7'd12;
      B8D4_CODE: return 7'd24;
      B8D2_CODE: return 7'd16;
      B4D2_CODE: return 7'd20;
      B2D1_CODE: return 7'd18;
      default:   return FULL;
    endcase
  endfunction

  // Bytes at or above the compressed size are don't-care upstream; zero them here.
  function automatic logic [SW-1:0] mask_bytes(input logic [SW-1:0] d, input logic [6:0] n);
    logic [SW-1:0] r;
    r = '0;
    for (int b = 0; b < SB; b++) begin
      if (7'(b) < n) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  logic [SW-1:0]   hold_data_q, hold_data_d;
  logic [3:0]      hold_mode_q, hold_mode_d;
  logic [15:0]     hold_boh_q, hold_boh_d;
  logic            hold_vld_q, hold_vld_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   out_data_q, out_data_d;
  logic [7:0]      out_mode_q, out_mode_d;
  logic [31:0]     out_boh_q, out_boh_d;
  logic [1:0]      out_cv_q, out_cv_d;
  logic            out_vld_q, out_vld_d;

  logic [6:0]      h_size, in_size;
  logic [SW-1:0]   in_masked;
  logic            o_free, in_fire, fits, lone_emit, emit_pair, emit_lone;

  always_comb begin
    h_size    = line_size(hold_mode_q);
    in_size   = line_size(in_mode);
    in_masked = mask_bytes(in_data, in_size);
    o_free    = !out_vld_q || out_ready;
    in_ready  = !hold_vld_q || o_free;
    in_fire   = in_valid && in_ready;
    fits      = (h_size != FULL) && (in_size != FULL) && ((h_size + in_size) <= FULL);
    lone_emit = hold_vld_q && !in_fire && o_free && ((cnt_q == CNT_MAX) || flush);
    emit_pair = in_fire && hold_vld_q && fits;
    emit_lone = (in_fire && hold_vld_q && !fits) || lone_emit;

    hold_data_d = hold_data_q;
    hold_mode_d = hold_mode_q;
    hold_boh_d  = hold_boh_q;
    hold_vld_d  = hold_vld_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    out_boh_d   = out_boh_q;
    out_cv_d    = out_cv_q;

    if (in_fire) begin
      hold_data_d = in_masked;
      hold_mode_d = in_mode;
      hold_boh_d  = in_base_one_hot;
      hold_vld_d  = !emit_pair;
      cnt_d       = '0;
    end else if (hold_vld_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (lone_emit) hold_vld_d = 1'b0;
    end

    // The held line always sits at byte 0; a partner lands right after it.
    if (emit_pair) begin
      out_data_d = hold_data_q | (in_masked << {h_size, 3'b000});
      out_mode_d = {in_mode, hold_mode_q};
      out_boh_d  = {in_base_one_hot, hold_boh_q};
      out_cv_d   = 2'b11;
    end else if (emit_lone) begin
      out_data_d = hold_data_q;
      out_mode_d = {NO_COMPR_CODE, hold_mode_q};
      out_boh_d  = {16'h0000, hold_boh_q};
      out_cv_d   = 2'b01;
    end

    if (emit_pair || emit_lone) out_vld_d = 1'b1;
    else if (out_ready)         out_vld_d = 1'b0;
    else                        out_vld_d = out_vld_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_mode_q <= 8'hFF;
      out_boh_q  <= '0;
      out_cv_q   <= 2'b00;
    end else begin
      hold_vld_q <= hold_vld_d;
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_mode_q <= out_mode_d;
      out_boh_q  <= out_boh_d;
      out_cv_q   <= out_cv_d;
    end
  end

  // Hold payload is qualified by hold_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    hold_mode_q <= hold_mode_d;
    hold_boh_q  <= hold_boh_d;
  end

  assign out_compressed_cachelines = out_data_q;
  assign out_compressed_mode       = out_mode_q;
  assign out_base_one_hot          = out_boh_q;
  assign out_cacheline_valid       = out_cv_q;
  assign out_valid                 = out_vld_q;

endmodule

// File: tb/tb_bdi_line_packer.sv
// Bench for bdi_line_packer: directed vector table, hand-written corner sequences,
// and a randomized run against a byte-level slot model.
module tb_bdi_line_packer;

  localparam int HT = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] in_data;
  logic [3:0]   in_mode;
  logic [15:0]  in_base_one_hot;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [255:0] out_compressed_cachelines;
  logic [7:0]   out_compressed_mode;
  logic [31:0]  out_base_one_hot;
  logic [1:0]   out_cacheline_valid;
  logic         out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bdi_line_packer dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .in_data                   (in_data),
    .in_mode                   (in_mode),
    .in_base_one_hot           (in_base_one_hot),
    .in_valid                  (in_valid),
    .in_ready                  (in_ready),
    .flush                     (flush),
    .out_compressed_cachelines (out_compressed_cachelines),
    .out_compressed_mode       (out_compressed_mode),
    .out_base_one_hot          (out_base_one_hot),
    .out_cacheline_valid       (out_cacheline_valid),
    .out_valid                 (out_valid),
    .out_ready                 (out_ready)
  );

  typedef struct {
    logic [255:0] data;
    logic [7:0]   mode;
    logic [31:0]  boh;
    logic [1:0]   cv;
  } slot_t;

  typedef struct {
    logic [3:0] ma;
    logic [3:0] mb;
    logic [7:0] exp_mode;
    logic [1:0] exp_cv;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_slot(input string nm, input slot_t e);
    chk({nm, "_data"}, out_compressed_cachelines, e.data);
    chk({nm, "_mode"}, 256'(out_compressed_mode), 256'(e.mode));
    chk({nm, "_boh"},  256'(out_base_one_hot), 256'(e.boh));
    chk({nm, "_cv"},   256'(out_cacheline_valid), 256'(e.cv));
  endtask

  function automatic int sz(input logic [3:0] m);
    case (m)
      4'd0: return 4;
      4'd1: return 8;
      4'd2: return 12;
      4'd3: return 12;
      4'd4: return 24;
      4'd5: return 16;
      4'd6: return 20;
      4'd7: return 18;
      default: return 32;
    endcase
  endfunction

  function automatic bit pair_fits(input logic [3:0] a, input logic [3:0] b);
    return (sz(a) != 32) && (sz(b) != 32) && (sz(a) + sz(b) <= 32);
  endfunction

  function automatic slot_t mk_pair(input logic [255:0] ld, input logic [3:0] lm, input logic [15:0] lb,
                                    input logic [255:0] md, input logic [3:0] mm, input logic [15:0] mb);
    slot_t s;
    int sl, sm;
    sl = sz(lm);
    sm = sz(mm);
    s.data = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < sl)           s.data[8*b +: 8] = ld[8*b +: 8];
      else if (b < sl + sm) s.data[8*b +: 8] = md[8*(b-sl) +: 8];
    end
    s.mode = {mm, lm};
    s.boh  = {mb, lb};
    s.cv   = 2'b11;
    return s;
  endfunction

  function automatic slot_t mk_lone(input logic [255:0] ld, input logic [3:0] lm, input logic [15:0] lb);
    slot_t s;
    s.data = '0;
    for (int b = 0; b < 32; b++)
      if (b < sz(lm)) s.data[8*b +: 8] = ld[8*b +: 8];
    s.mode = {4'hF, lm};
    s.boh  = {16'h0000, lb};
    s.cv   = 2'b01;
    return s;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put_line(input logic [3:0] m, input logic [255:0] d, input logic [15:0] b);
    in_valid = 1'b1;
    in_mode = m;
    in_data = d;
    in_base_one_hot = b;
    #1;
    chk("put_in_ready", 256'(in_ready), 256'(1'b1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    step();
    step();
  endtask

  task automatic tp_basic();
    logic [255:0] da, db;
    da = rnd256();
    da[31:0] = 32'hDEADBEEF;
    db = rnd256();
    db[95:0] = {12{8'hA5}};
    put_line(4'd0, da, 16'h0001);
    put_line(4'd2, db, 16'h0002);
    chk("basic_valid", 256'(out_valid), 256'(1'b1));
    chk("basic_data", out_compressed_cachelines, {128'h0, {12{8'hA5}}, 32'hDEADBEEF});
    chk("basic_mode", 256'(out_compressed_mode), 256'(8'h20));
    chk("basic_boh", 256'(out_base_one_hot), 256'(32'h0002_0001));
    chk("basic_cv", 256'(out_cacheline_valid), 256'(2'b11));
    drain();
  endtask

  task automatic run_table();
    vec_t vt[11];
    logic [255:0] da, db;
    logic [15:0] ba, bb;
    slot_t e;
    vt[0]  = '{4'd0, 4'd2, 8'h20, 2'b11};
    vt[1]  = '{4'd4, 4'd6, 8'hF4, 2'b01};
    vt[2]  = '{4'd15, 4'd0, 8'hFF, 2'b01};
    vt[3]  = '{4'd1, 4'd7, 8'h71, 2'b11};
    vt[4]  = '{4'd6, 4'd1, 8'h16, 2'b11};
    vt[5]  = '{4'd5, 4'd5, 8'h55, 2'b11};
    vt[6]  = '{4'd7, 4'd5, 8'hF7, 2'b01};
    vt[7]  = '{4'd0, 4'd9, 8'hF0, 2'b01};
    vt[8]  = '{4'd3, 4'd2, 8'h23, 2'b11};
    vt[9]  = '{4'd9, 4'd0, 8'hF9, 2'b01};
    vt[10] = '{4'd4, 4'd1, 8'h14, 2'b11};
    for (int i = 0; i < 11; i++) begin
      da = rnd256();
      db = rnd256();
      ba = 16'($urandom());
      bb = 16'($urandom());
      put_line(vt[i].ma, da, ba);
      put_line(vt[i].mb, db, bb);
      e = (vt[i].exp_cv == 2'b11) ? mk_pair(da, vt[i].ma, ba, db, vt[i].mb, bb) : mk_lone(da, vt[i].ma, ba);
      chk("tbl_valid", 256'(out_valid), 256'(1'b1));
      chk("tbl_mode_const", 256'(out_compressed_mode), 256'(vt[i].exp_mode));
      chk("tbl_cv_const", 256'(out_cacheline_valid), 256'(vt[i].exp_cv));
      chk_slot("tbl", e);
      flush = 1'b1;
      step();
      flush = 1'b0;
      if (vt[i].exp_cv == 2'b01) begin
        chk("tbl_flush_valid", 256'(out_valid), 256'(1'b1));
        chk_slot("tbl_flush", mk_lone(db, vt[i].mb, bb));
      end else begin
        chk("tbl_noflush_valid", 256'(out_valid), 256'(1'b0));
      end
      step();
      step();
    end
  endtask

  task automatic tp_nofit();
    logic [255:0] da, db, dc;
    logic [15:0] bb, bc;
    da = rnd256();
    db = rnd256();
    dc = rnd256();
    bb = 16'($urandom());
    bc = 16'($urandom());
    put_line(4'd4, da, 16'h0010);
    put_line(4'd6, db, bb);
    chk("nofit_mode", 256'(out_compressed_mode), 256'(8'hF4));
    chk("nofit_cv", 256'(out_cacheline_valid), 256'(2'b01));
    chk("nofit_data", out_compressed_cachelines, {64'h0, da[191:0]});
    put_line(4'd1, dc, bc);
    chk("nofit2_valid", 256'(out_valid), 256'(1'b1));
    chk("nofit2_mode", 256'(out_compressed_mode), 256'(8'h16));
    chk("nofit2_data", out_compressed_cachelines, {32'h0, dc[63:0], db[159:0]});
    chk("nofit2_boh", 256'(out_base_one_hot), 256'({bc, bb}));
    drain();
  endtask

  task automatic tp_timeout();
    logic [255:0] da, db;
    int got;
    da = rnd256();
    db = rnd256();
    got = 0;
    put_line(4'd15, da, 16'h1234);
    put_line(4'd0, db, 16'h0008);
    chk("nc_data", out_compressed_cachelines, da);
    chk("nc_mode", 256'(out_compressed_mode), 256'(8'hFF));
    chk("nc_cv", 256'(out_cacheline_valid), 256'(2'b01));
    for (int k = 1; k <= 40; k++) begin
      step();
      if (out_valid) begin
        got = k;
        break;
      end
    end
    chk("timeout_cycles", 256'(got), 256'(HT));
    chk("timeout_mode", 256'(out_compressed_mode), 256'(8'hF0));
    chk("timeout_data", out_compressed_cachelines, {224'h0, db[31:0]});
    drain();
  endtask

  task automatic tp_backpressure();
    logic [255:0] da, db, dc;
    slot_t e;
    da = rnd256();
    db = rnd256();
    dc = rnd256();
    out_ready = 1'b0;
    put_line(4'd15, da, 16'h00AA);
    put_line(4'd1, db, 16'h0004);
    e = mk_lone(da, 4'd15, 16'h00AA);
    flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", 256'(in_ready), 256'(1'b0));
      chk("bp_valid", 256'(out_valid), 256'(1'b1));
      chk_slot("bp_stable", e);
      step();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_mode = 4'd7;
    in_data = dc;
    in_base_one_hot = 16'h0040;
    #1;
    chk("bp_release_in_ready", 256'(in_ready), 256'(1'b1));
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    chk("bp_pair_valid", 256'(out_valid), 256'(1'b1));
    chk("bp_pair_mode", 256'(out_compressed_mode), 256'(8'h71));
    chk("bp_pair_data", out_compressed_cachelines, {48'h0, dc[143:0], db[63:0]});
    chk_slot("bp_pair", mk_pair(db, 4'd1, 16'h0004, dc, 4'd7, 16'h0040));
    step();
    chk("bp_hold_empty", 256'(in_ready), 256'(1'b1));
    chk("bp_pair_kept", 256'(out_compressed_mode), 256'(8'h71));
    out_ready = 1'b1;
    step();
    chk("bp_drained", 256'(out_valid), 256'(1'b0));
    drain();
  endtask

  task automatic tp_reset();
    logic [255:0] dx, dy;
    dx = rnd256();
    dy = rnd256();
    out_ready = 1'b0;
    put_line(4'd15, rnd256(), 16'hFFFF);
    put_line(4'd0, rnd256(), 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 256'(out_valid), 256'(1'b0));
    chk("arst_data", out_compressed_cachelines, 256'h0);
    chk("arst_mode", 256'(out_compressed_mode), 256'(8'hFF));
    chk("arst_boh", 256'(out_base_one_hot), 256'h0);
    chk("arst_cv", 256'(out_cacheline_valid), 256'(2'b00));
    chk("arst_in_ready", 256'(in_ready), 256'(1'b1));
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_idle", 256'(out_valid), 256'(1'b0));
    put_line(4'd0, dx, 16'h0100);
    chk("post_rst_no_stale", 256'(out_valid), 256'(1'b0));
    put_line(4'd1, dy, 16'h0200);
    chk("post_rst_valid", 256'(out_valid), 256'(1'b1));
    chk("post_rst_mode", 256'(out_compressed_mode), 256'(8'h10));
    chk_slot("post_rst", mk_pair(dx, 4'd0, 16'h0100, dy, 4'd1, 16'h0200));
    drain();
  endtask

  task automatic run_random();
    slot_t mq[$];
    logic [255:0] hd;
    logic [3:0] hm;
    logic [15:0] hb;
    bit hv, ofree, mir, fire;
    int age, p_in;
    hv = 0;
    age = 0;
    hd = '0;
    hm = '0;
    hb = '0;
    p_in = 60;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 256 == 0) begin
        case ($urandom_range(0, 2))
          0: p_in = 70;
          1: p_in = 20;
          default: p_in = 3;
        endcase
      end
      in_valid = ($urandom_range(0, 99) < p_in);
      in_mode = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      in_data = rnd256();
      in_base_one_hot = 16'($urandom());
      out_ready = ($urandom_range(0, 99) < 70);
      flush = ($urandom_range(0, 99) < 4);
      #1;
      ofree = (mq.size() == 0) || out_ready;
      mir = !hv || ofree;
      chk("rnd_in_ready", 256'(in_ready), 256'(mir));
      chk("rnd_out_valid", 256'(out_valid), 256'(mq.size() != 0));
      if (mq.size() != 0 && out_valid) chk_slot("rnd_slot", mq[0]);
      fire = in_valid && mir;
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (fire) begin
        if (hv && pair_fits(hm, in_mode)) begin
          mq.push_back(mk_pair(hd, hm, hb, in_data, in_mode, in_base_one_hot));
          hv = 0;
        end else begin
          if (hv) mq.push_back(mk_lone(hd, hm, hb));
          hd = in_data;
          hm = in_mode;
          hb = in_base_one_hot;
          hv = 1;
          age = 0;
        end
      end else if (hv) begin
        if (ofree && (age == HT - 1 || flush)) begin
          mq.push_back(mk_lone(hd, hm, hb));
          hv = 0;
        end else if (age < HT - 1) begin
          age++;
        end
      end
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    in_mode = '0;
    in_base_one_hot = '0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_data", out_compressed_cachelines, 256'h0);
    chk("rst_mode", 256'(out_compressed_mode), 256'(8'hFF));
    chk("rst_boh", 256'(out_base_one_hot), 256'h0);
    chk("rst_cv", 256'(out_cacheline_valid), 256'(2'b00));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    tp_basic();
    run_table();
    tp_nofit();
    tp_timeout();
    tp_backpressure();
    tp_reset();
    run_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
